// File: rtl/pc_gen.sv
// Fetch program-counter generator: sequential +2/+4 advance, prioritised redirects,
// debug halt/resume and misaligned-target reporting.

module pc_gen_redir_lane #(
  parameter int ADDR_W = 32,
  parameter int C_EXT  = 1
) (
  input  logic [ADDR_W-1:0] raw,
  output logic [ADDR_W-1:0] aligned,
  output logic              mis
);
  localparam logic [ADDR_W-1:0] MASK = (C_EXT != 0) ? ADDR_W'(1) : ADDR_W'(3);

  assign aligned = raw & ~MASK;
  assign mis     = |(raw & MASK);
endmodule

module pc_gen #(
  parameter int                 ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  RESET_VEC = '0,
  parameter int                 N_REDIR   = 3,
  parameter int                 C_EXT     = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      hold_i,
  input  logic                      step_c_i,
  input  logic [N_REDIR-1:0]        redir_valid_i,
  input  logic [N_REDIR*ADDR_W-1:0] redir_addr_i,
  input  logic                      halt_req_i,
  input  logic                      resume_i,
  input  logic                      fetch_ready_i,
  output logic                      fetch_valid_o,
  output logic [ADDR_W-1:0]         fetch_pc_o,
  output logic                      fetch_kill_o,
  output logic [N_REDIR-1:0]        redir_sel_o,
  output logic                      misalign_o,
  output logic [ADDR_W-1:0]         misalign_addr_o,
  output logic                      halted_o
);
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t                          state;
  logic [ADDR_W-1:0]               pc;
  logic [N_REDIR-1:0][ADDR_W-1:0]  tgt_raw, tgt_al;
  logic [N_REDIR-1:0]              tgt_mis;
  logic [N_REDIR-1:0]              win_sel;
  logic [ADDR_W-1:0]               win_pc, win_raw, step;
  logic                            win_mis, redir_any;

  assign tgt_raw = redir_addr_i;

  genvar g;
  generate
    for (g = 0; g < N_REDIR; g++) begin : g_lane
      pc_gen_redir_lane #(.ADDR_W(ADDR_W), .C_EXT(C_EXT)) u_lane (
        .raw     (tgt_raw[g]),
        .aligned (tgt_al[g]),
        .mis     (tgt_mis[g])
      );
    end
  endgenerate

  // Scan high to low so the lowest requesting channel is the last one written.
  always_comb begin
    win_sel = '0;
    win_pc  = '0;
    win_raw = '0;
    win_mis = 1'b0;
    for (int k = N_REDIR-1; k >= 0; k--) begin
      if (redir_valid_i[k]) begin
        win_sel    = '0;
        win_sel[k] = 1'b1;
        win_pc     = tgt_al[k];
        win_raw    = tgt_raw[k];
        win_mis    = tgt_mis[k];
      end
    end
  end

  assign redir_any    = |redir_valid_i;
  assign step         = ((C_EXT != 0) && step_c_i) ? ADDR_W'(2) : ADDR_W'(4);
  assign fetch_kill_o = fetch_valid_o & redir_any;
  assign fetch_pc_o   = pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= BOOT;
      pc              <= RESET_VEC;
      fetch_valid_o   <= 1'b0;
      redir_sel_o     <= '0;
      misalign_o      <= 1'b0;
      misalign_addr_o <= '0;
      halted_o        <= 1'b0;
    end else begin
      redir_sel_o <= win_sel;
      misalign_o  <= redir_any & win_mis;
      if (redir_any && win_mis) misalign_addr_o <= win_raw;

      if (redir_any)
        pc <= win_pc;
      else if (state == RUN && !hold_i && fetch_ready_i)
        pc <= pc + step;

      case (state)
        BOOT: begin
          state         <= RUN;
          fetch_valid_o <= 1'b1;
          halted_o      <= 1'b0;
        end
        RUN: if (halt_req_i) begin
          state         <= HALT;
          fetch_valid_o <= 1'b0;
          halted_o      <= 1'b1;
        end
        HALT: if (resume_i) begin
          state         <= RUN;
          fetch_valid_o <= 1'b1;
          halted_o      <= 1'b0;
        end
        default: begin
          state         <= BOOT;
          fetch_valid_o <= 1'b0;
          halted_o      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: a C_EXT=1 and a C_EXT=0 instance share stimulus and are
// checked every cycle against an arithmetic reference model.

module tb_pc_gen;
  localparam int AW = 32;
  localparam int NR = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n, hold, step_c, halt_req, resume, ready;
  logic [NR-1:0]        rv;
  logic [NR-1:0][AW-1:0] ra;

  logic          c_valid, c_kill, c_mis, c_halted;
  logic [AW-1:0] c_pc, c_maddr;
  logic [NR-1:0] c_sel;
  logic          n_valid, n_kill, n_mis, n_halted;
  logic [AW-1:0] n_pc, n_maddr;
  logic [NR-1:0] n_sel;

  pc_gen #(.ADDR_W(AW), .RESET_VEC('0), .N_REDIR(NR), .C_EXT(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .hold_i(hold), .step_c_i(step_c),
    .redir_valid_i(rv), .redir_addr_i(ra), .halt_req_i(halt_req), .resume_i(resume),
    .fetch_ready_i(ready), .fetch_valid_o(c_valid), .fetch_pc_o(c_pc),
    .fetch_kill_o(c_kill), .redir_sel_o(c_sel), .misalign_o(c_mis),
    .misalign_addr_o(c_maddr), .halted_o(c_halted));

  pc_gen #(.ADDR_W(AW), .RESET_VEC('0), .N_REDIR(NR), .C_EXT(0)) dut_n (
    .clk(clk), .rst_n(rst_n), .hold_i(hold), .step_c_i(step_c),
    .redir_valid_i(rv), .redir_addr_i(ra), .halt_req_i(halt_req), .resume_i(resume),
    .fetch_ready_i(ready), .fetch_valid_o(n_valid), .fetch_pc_o(n_pc),
    .fetch_kill_o(n_kill), .redir_sel_o(n_sel), .misalign_o(n_mis),
    .misalign_addr_o(n_maddr), .halted_o(n_halted));

  // mode: 0 = booting, 1 = fetching, 2 = halted
  typedef struct {
    int            mode;
    logic [AW-1:0] pc;
    logic [NR-1:0] sel;
    bit            mis;
    logic [AW-1:0] maddr;
  } mdl_t;
  typedef struct { mdl_t c; mdl_t n; } exp_t;

  mdl_t m_c, m_n;
  exp_t q[$];
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic mdl_t model_step(input mdl_t m, input bit cext);
    mdl_t n = m;
    int win = -1;
    int unsigned lowmod = cext ? 2 : 4;
    if (!rst_n) begin
      n.mode = 0; n.pc = '0; n.sel = '0; n.mis = 0; n.maddr = '0;
      return n;
    end
    for (int i = 0; i < NR; i++) if (rv[i] && win < 0) win = i;
    n.sel = '0;
    n.mis = 0;
    if (win >= 0) begin
      n.pc  = ra[win] - (ra[win] % lowmod);
      n.sel = NR'(1 << win);
      if (ra[win] % lowmod != 0) begin n.mis = 1; n.maddr = ra[win]; end
    end else if (m.mode == 1 && !hold && ready) begin
      n.pc = m.pc + ((cext && step_c) ? 2 : 4);
    end
    if (m.mode == 0) n.mode = 1;
    else if (m.mode == 1 && halt_req) n.mode = 2;
    else if (m.mode == 2 && resume) n.mode = 1;
    return n;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    m_c = model_step(m_c, 1'b1);
    m_n = model_step(m_n, 1'b0);
    e.c = m_c; e.n = m_n;
    q.push_back(e);
  end

  initial begin
    exp_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL sb_empty: no expected entry at %0t", $time);
      end else begin
        e = q.pop_front();
        chk("c_valid",  AW'(c_valid),  AW'(e.c.mode == 1));
        chk("c_halted", AW'(c_halted), AW'(e.c.mode == 2));
        chk("c_pc",     c_pc,          e.c.pc);
        chk("c_sel",    AW'(c_sel),    AW'(e.c.sel));
        chk("c_mis",    AW'(c_mis),    AW'(e.c.mis));
        chk("c_maddr",  c_maddr,       e.c.maddr);
        chk("c_kill",   AW'(c_kill),   AW'(e.c.mode == 1 && rv != 0));
        chk("n_valid",  AW'(n_valid),  AW'(e.n.mode == 1));
        chk("n_halted", AW'(n_halted), AW'(e.n.mode == 2));
        chk("n_pc",     n_pc,          e.n.pc);
        chk("n_sel",    AW'(n_sel),    AW'(e.n.sel));
        chk("n_mis",    AW'(n_mis),    AW'(e.n.mis));
        chk("n_maddr",  n_maddr,       e.n.maddr);
        chk("n_kill",   AW'(n_kill),   AW'(e.n.mode == 1 && rv != 0));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic redir(input int ch, input logic [AW-1:0] a);
    rv = '0;
    rv[ch] = 1'b1;
    ra[ch] = a;
  endtask

  initial begin
    rst_n = 0; hold = 0; step_c = 0; halt_req = 0; resume = 0; ready = 1;
    rv = '0; ra = '0;
    tick(); tick();
    rst_n = 1;
    chk("rst_valid", AW'(c_valid), 0);
    chk("rst_pc", c_pc, 32'h0);
    chk("rst_halted", AW'(c_halted), 0);
    tick();
    chk("boot_valid", AW'(c_valid), 1);
    chk("seq_pc0", c_pc, 32'h0);
    tick(); chk("seq_pc4", c_pc, 32'h4);
    tick(); chk("seq_pc8", c_pc, 32'h8);

    ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("stall_pc", c_pc, 32'h8); chk("stall_valid", AW'(c_valid), 1);
    end
    hold = 1; ready = 1;
    for (int i = 0; i < 2; i++) begin tick(); chk("hold_pc", c_pc, 32'h8); end
    hold = 0;
    tick(); chk("unhold_pc", c_pc, 32'hC);

    hold = 1; rv = 3'b110; ra[1] = 32'h2000; ra[2] = 32'h3000;
    #1 chk("kill", AW'(c_kill), 1);
    tick();
    chk("redir_pc", c_pc, 32'h2000);
    chk("redir_sel", AW'(c_sel), 32'h2);
    rv = '0; hold = 0;

    ready = 0; redir(0, 32'h100); tick();
    chk("r100_pc", c_pc, 32'h100);
    rv = '0; ready = 1; step_c = 1;
    tick(); chk("c_step2", c_pc, 32'h102); chk("n_step2", n_pc, 32'h104);
    step_c = 0;
    tick(); chk("c_step4", c_pc, 32'h106); chk("n_step4", n_pc, 32'h108);

    ready = 0; redir(0, 32'h1003); tick();
    chk("c_mis_pc", c_pc, 32'h1002); chk("c_mis", AW'(c_mis), 1); chk("c_maddr", c_maddr, 32'h1003);
    rv = '0; tick();
    chk("c_mis_pulse", AW'(c_mis), 0);
    redir(0, 32'h1002); tick();
    chk("n_mis_pc", n_pc, 32'h1000); chk("n_mis", AW'(n_mis), 1); chk("n_maddr", n_maddr, 32'h1002);
    chk("c_nomis", AW'(c_mis), 0);
    rv = '0; tick();

    redir(0, 32'h40); tick(); rv = '0;
    halt_req = 1; tick(); halt_req = 0;
    chk("halt_h", AW'(c_halted), 1); chk("halt_v", AW'(c_valid), 0); chk("halt_pc", c_pc, 32'h40);
    redir(0, 32'h80); tick(); rv = '0;
    chk("halt_redir_pc", c_pc, 32'h80); chk("halt_still", AW'(c_halted), 1);
    resume = 1; tick(); resume = 0;
    chk("resume_v", AW'(c_valid), 1); chk("resume_pc", c_pc, 32'h80);
    halt_req = 1; tick(); halt_req = 0;
    rst_n = 0; tick(); rst_n = 1;
    chk("rst_halt_h", AW'(c_halted), 0); chk("rst_halt_pc", c_pc, 32'h0);

    tick();
    redir(0, 32'hFFFF_FFFC); tick(); rv = '0;
    ready = 1; tick();
    chk("wrap_pc", c_pc, 32'h0); chk("wrap_pc_n", n_pc, 32'h0);

    for (int i = 0; i < 3000; i++) begin
      rst_n    = ($urandom_range(0, 99) != 0);
      hold     = ($urandom_range(0, 3) == 0);
      ready    = ($urandom_range(0, 3) != 0);
      step_c   = $urandom_range(0, 1);
      halt_req = ($urandom_range(0, 15) == 0);
      resume   = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < NR; k++) begin
        rv[k] = ($urandom_range(0, 9) == 0);
        ra[k] = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | AW'($urandom_range(0, 15))) : $urandom;
      end
      tick();
    end
    rv = '0;
    tick(); tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
